// File: rtl/spi_master_engine.sv
// SPI mode-0 initiator with a chunked command/status handshake.
// Generates SS/SCLK/MOSI from sys_clk and captures MISO MSB-first into a right-aligned buffer.
module spi_master_engine #(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE+1),
    parameter int CLK_DIV          = 4,
    parameter int SS_SETUP         = 2,
    parameter int SS_HOLD          = 2
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        cmd_start,
    input  logic                        cmd_next_chunk,
    input  logic                        cmd_finish,
    input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
    input  logic [BUF_SIZE-1:0]         mosi_data,
    input  logic                        miso_in,
    output logic                        mosi_out,
    output logic                        sclk_out,
    output logic                        ss_out,
    output logic                        comm_active,
    output logic                        bus_ready,
    output logic [BUF_SIZE-1:0]         miso_data
);
    localparam int CW      = CHUNK_SIZE_WIDTH;
    localparam int CNT_MAX = (CLK_DIV > SS_SETUP) ? ((CLK_DIV > SS_HOLD) ? CLK_DIV : SS_HOLD)
                                                  : ((SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX+1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV-1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP-1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD-1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CW-1:0]    BUF_N      = CW'(BUF_SIZE);
    localparam logic [CW-1:0]    BITS_ONE   = CW'(1);
    localparam logic [CW-1:0]    BITS_ZERO  = '0;

    typedef enum logic [2:0] {IDLE, SETUP, COMM, LOW, HIGH, HOLD} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CW-1:0]       bits_q;
    logic [BUF_SIZE-1:0] tx_q, rx_q, miso_q;
    logic                ss_q, sclk_q, mosi_q, ready_q;

    logic [CW-1:0]       n_d, shamt_d;
    logic [BUF_SIZE-1:0] tx_d;

    // Left-align the chunk so the next bit to send is always the register MSB.
    always_comb begin
        n_d     = (next_chunk_size > BUF_N) ? BUF_N : next_chunk_size;
        shamt_d = BUF_N - n_d;
        tx_d    = mosi_data << shamt_d;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            miso_q  <= '0;
            ss_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (cmd_start) begin
                    ss_q    <= 1'b1;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= SETUP;
                end
                SETUP: if (cnt_q == SETUP_LAST) begin
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    state_q <= COMM;
                end else cnt_q <= cnt_q + CNT_ONE;
                COMM: if (!ready_q) begin
                    // Zero-length chunk completes one cycle after acceptance.
                    ready_q <= 1'b1;
                    miso_q  <= '0;
                end else if (cmd_next_chunk) begin
                    ready_q <= 1'b0;
                    rx_q    <= '0;
                    cnt_q   <= '0;
                    bits_q  <= n_d;
                    tx_q    <= tx_d;
                    if (n_d != BITS_ZERO) begin
                        mosi_q  <= tx_d[BUF_SIZE-1];
                        state_q <= LOW;
                    end
                end else if (cmd_finish) begin
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= HOLD;
                end
                LOW: if (cnt_q == DIV_LAST) begin
                    cnt_q   <= '0;
                    sclk_q  <= 1'b1;
                    rx_q    <= {rx_q[BUF_SIZE-2:0], miso_in};
                    state_q <= HIGH;
                end else cnt_q <= cnt_q + CNT_ONE;
                HIGH: if (cnt_q == DIV_LAST) begin
                    cnt_q  <= '0;
                    sclk_q <= 1'b0;
                    if (bits_q > BITS_ONE) begin
                        bits_q  <= bits_q - BITS_ONE;
                        tx_q    <= tx_q << 1;
                        mosi_q  <= tx_q[BUF_SIZE-2];
                        state_q <= LOW;
                    end else begin
                        miso_q  <= rx_q;
                        ready_q <= 1'b1;
                        state_q <= COMM;
                    end
                end else cnt_q <= cnt_q + CNT_ONE;
                HOLD: if (cnt_q == HOLD_LAST) begin
                    cnt_q   <= '0;
                    ss_q    <= 1'b0;
                    mosi_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end else cnt_q <= cnt_q + CNT_ONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mosi_out    = mosi_q;
    assign sclk_out    = sclk_q;
    assign ss_out      = ss_q;
    assign comm_active = ss_q;
    assign bus_ready   = ready_q;
    assign miso_data   = miso_q;
endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

Active SPI initiator for the MITM fabric: it generates SS, SCLK and MOSI from `sys_clk` and captures MISO, so the logic module can originate a transaction instead of only relaying or altering one. Its command and status interface matches the passive bus controller: `cmd_start`, `cmd_next_chunk`, `cmd_finish`, `next_chunk_size`, `comm_active` and `bus_ready`. Downstream MITM logic can therefore drive either block without change. Its outputs feed the fake-line inputs of the output multiplexer.

## Interface
- `BUF_SIZE`, 9: maximum bits per chunk.
- `CHUNK_SIZE_WIDTH`, `$clog2(BUF_SIZE+1)`: width of the chunk size field.
- `CLK_DIV`, 4: `sys_clk` cycles per SCLK half-period; must be ≥1.
- `SS_SETUP`, 2: cycles from SS assert until `bus_ready` rises; must be ≥1.
- `SS_HOLD`, 2: cycles from `cmd_finish` until SS deasserts; must be ≥1.
- `sys_clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_start`  in  1  open a transaction; honoured only in IDLE.
- `cmd_next_chunk`  in  1  transfer one chunk; honoured only in COMM.
- `cmd_finish`  in  1  close the transaction; honoured only in COMM.
- `next_chunk_size`  in  CHUNK_SIZE_WIDTH  bits in the chunk; sampled with `cmd_next_chunk`.
- `mosi_data`  in  BUF_SIZE  data to transmit; sampled with `cmd_next_chunk`.
- `miso_in`  in  1  MISO line from the slave.
- `mosi_out`, `sclk_out`, `ss_out`  out  1 each  driven bus lines; all registered.
- `comm_active`  out  1  high from SS assert to SS deassert.
- `bus_ready`  out  1  high when a command will be accepted.
- `miso_data`  out  BUF_SIZE  bits received in the last chunk; registered.

## Operation
- Reset values, applied asynchronously while `rst`=1:
  - state IDLE;
  - `sclk_out`, `mosi_out`, `ss_out`, `comm_active` all 0;
  - `bus_ready`=1;
  - `miso_data`=0;
  - all counters 0.
- SS polarity follows the bus convention: `ss_out`=1 means a transaction is active; a rising edge opens it.
- SPI mode 0:
  - SCLK idles low;
  - MOSI changes on the falling edge (or at chunk start);
  - MISO is sampled on the rising edge.
- States: IDLE, SETUP, COMM, LOW, HIGH, HOLD.
- IDLE + `cmd_start`:
  - `ss_out`, `comm_active` ← 1;
  - `bus_ready` ← 0;
  - go to SETUP.
- SETUP: wait `SS_SETUP` cycles, then `bus_ready` ← 1 and go to COMM.
- COMM + `cmd_next_chunk`:
  - latch N=min(`next_chunk_size`, BUF_SIZE) and `mosi_data`;
  - `bus_ready` ← 0;
  - `miso_data` shift register ← 0.
- Chunk with N=0: no SCLK edges; `bus_ready` ← 1 on the next edge; `miso_data` becomes 0; return to COMM.
- Chunk with N>0: `mosi_out` ← `mosi_data[N-1]`; go to LOW.
- Bit order is MSB first within the chunk: transmitted bits are index N-1 down to 0.
- LOW: hold `sclk_out`=0 for `CLK_DIV` cycles.
  - On leaving LOW, `sclk_out` ← 1 and `miso_in` is shifted into the LSB of the receive register, all at that same edge.
- HIGH: hold `sclk_out`=1 for `CLK_DIV` cycles, then `sclk_out` ← 0.
  - If bits remain, `mosi_out` ← next bit and go to LOW.
  - Otherwise `miso_data` ← receive register, `bus_ready` ← 1, and return to COMM.
- Received bits are right-aligned: the first bit received ends up at `miso_data[N-1]`; bits N..BUF_SIZE-1 read 0.
- COMM + `cmd_finish` (with `cmd_next_chunk`=0): `bus_ready` ← 0; go to HOLD.
- HOLD: after `SS_HOLD` cycles:
  - `ss_out`, `comm_active`, `mosi_out` ← 0;
  - `bus_ready` ← 1;
  - go to IDLE.
- Simultaneous `cmd_next_chunk` and `cmd_finish` in COMM: `cmd_next_chunk` wins and `cmd_finish` is dropped.
- Commands in any state other than the one named above are ignored and are not queued.
- `rst` mid-chunk: lines return immediately to reset values and the partial `miso_data` is discarded.

## Timing
- Commands are sampled on the rising edge of `sys_clk`. Call the accepting edge E0.
- `cmd_start`: `ss_out`=1 after E0; `bus_ready`=1 after E0+`SS_SETUP`.
- Chunk of N>0 bits:
  - rising SCLK edges at E0+(2k+1)·`CLK_DIV`, for k=0..N-1;
  - falling SCLK edges at E0+(2k+2)·`CLK_DIV`;
  - `bus_ready` and the updated `miso_data` appear at E0+2·`CLK_DIV`·N, on the same edge as the last SCLK fall.
- Each MOSI bit is stable for `CLK_DIV` cycles before and after the rising SCLK edge that samples it.
- `cmd_finish`: `ss_out`=0 after E0+`SS_HOLD`; `sclk_out` stays 0 throughout HOLD.
- `bus_ready` is never high while `sclk_out`=1.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → all outputs at their reset values before the next clock edge; `bus_ready`=1.
- Loopback (`miso_in`=`mosi_out`), `CLK_DIV`=2: `cmd_start`, then `cmd_next_chunk` with N=8 and `mosi_data`=9'h0A5.
  - Expect 8 SCLK pulses and MOSI sequence 1,0,1,0,0,1,0,1.
  - Expect `bus_ready` 32 cycles after acceptance and `miso_data`=9'h0A5.
- Full chunk: N=9, `miso_in` tied 1 → `miso_data`=9'h1FF. Repeat with N=12 → clamped to 9 bits, exactly 9 pulses.
- N=0 → no SCLK activity; `bus_ready` back to 1 one cycle later; `miso_data`=0.
- Command priority:
  - `cmd_next_chunk` and `cmd_finish` together → chunk runs and SS stays 1;
  - `cmd_next_chunk` pulsed while busy → ignored, pulse count unchanged;
  - `cmd_finish` → `ss_out`=0 exactly `SS_HOLD` cycles later, `comm_active`=0.
- Reset during the HIGH phase of bit 3 → `sclk_out`=0 and `ss_out`=0 immediately.
  - After release, a fresh `cmd_start` plus N=4 chunk completes with correct data.
